lcg_ctrl: RTL and testbench

Sequencer for a linear congruential generator: x(n+1) = (A * x(n) + C) mod 2^WIDTH.
- Owns the generator state register.
- Drives the shared iterative multiplier over its enable/done handshake (upstream of the multiplier), then adds the increment to the multiplier's truncated product (downstream of it).
- Presents each new word on a one-entry valid/ready output.

---
 rtl/lcg_ctrl.sv | 149 ++++++++++++++
 tb/tb_lcg_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcg_ctrl.sv
// lcg_ctrl: LCG sequencer x(n+1) = A*x(n) + C mod 2^WIDTH.
// Drives an external iterative multiplier and presents words on valid/ready.
module lcg_ctrl #(
   parameter int          WIDTH       = 32,
   parameter logic [31:0] MULT_A      = 32'd1664525,
   parameter logic [31:0] INC_C       = 32'd1013904223,
   parameter int          TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             err,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   output logic             mul_enable,
   input  logic             mul_done,
   input  logic [WIDTH-1:0] mul_result
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [WIDTH-1:0] A_W      = WIDTH'(MULT_A);
   localparam logic [WIDTH-1:0] C_W      = WIDTH'(INC_C);

   typedef enum logic [2:0] {
      IDLE,
      MUL_REQ,
      MUL_REL,
      ADD,
      DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             en_q, en_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum;

   assign sum        = prod_q + C_W;
   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign err        = err_q;
   assign mul_enable = en_q;
   assign mul_a      = x_q;
   assign mul_b      = A_W;
   assign busy       = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         prod_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         en_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         prod_q  <= prod_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         en_q    <= en_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      prod_d  = prod_q;
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      en_d    = en_q;
      cnt_d   = cnt_q;

      if (valid_q && out_ready)
         valid_d = 1'b0;

      // a seed always wins: drop the request and discard any pending word
      if (seed_load) begin
         x_d     = seed_data;
         err_d   = 1'b0;
         valid_d = 1'b0;
         en_d    = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (!seed_load && run && !valid_q && !mul_done) begin
               en_d    = 1'b1;
               cnt_d   = '0;
               state_d = MUL_REQ;
            end
         end
         MUL_REQ: begin
            if (seed_load) begin
               state_d = DRAIN;
            end else if (mul_done) begin
               prod_d  = mul_result;
               en_d    = 1'b0;
               state_d = MUL_REL;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               en_d    = 1'b0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         MUL_REL: begin
            if (seed_load)
               state_d = DRAIN;
            else if (!mul_done)
               state_d = ADD;
         end
         ADD: begin
            if (!seed_load) begin
               x_d     = sum;
               data_d  = sum;
               valid_d = 1'b1;
            end
            state_d = IDLE;
         end
         DRAIN: begin
            if (!mul_done)
               state_d = IDLE;
         end
         default: begin
            en_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lcg_ctrl.sv
// tb_lcg_ctrl: directed bench for lcg_ctrl.
// Uses a behavioural iterative multiplier with selectable hang/hold modes.
module tb_lcg_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        seed_load = 1'b0;
   logic [31:0] seed_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        busy;
   logic        err;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_enable;
   logic        mul_done = 1'b0;
   logic [31:0] mul_result = '0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int viol = 0;
   logic en_prev = 1'b0;

   localparam int LAT = 4;
   bit hang = 1'b0;
   int hold_extra = 0;
   int mcyc = 0;
   int mhold = 0;

   always #5 clk = ~clk;

   lcg_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .seed_load  (seed_load),
      .seed_data  (seed_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .err        (err),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_enable (mul_enable),
      .mul_done   (mul_done),
      .mul_result (mul_result)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mul_enable) begin
         mhold <= hold_extra;
         if (!hang) begin
            if (mcyc >= LAT - 1) begin
               mul_done   <= 1'b1;
               mul_result <= mul_a * mul_b;
            end else begin
               mcyc <= mcyc + 1;
            end
         end
      end else begin
         mcyc <= 0;
         if (mul_done) begin
            if (mhold == 0)
               mul_done <= 1'b0;
            else
               mhold <= mhold - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (mul_enable && !en_prev && mul_done)
         viol <= viol + 1;
      en_prev <= mul_enable;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int maxc);
      int n = 0;
      while (!out_valid && n < maxc) begin
         tick();
         n++;
      end
      chk("valid_seen", 64'(out_valid), 64'd1);
   endtask

   task automatic wait_en(input int maxc);
      int n = 0;
      while (!mul_enable && n < maxc) begin
         tick();
         n++;
      end
      chk("enable_seen", 64'(mul_enable), 64'd1);
   endtask

   task automatic seed(input logic [31:0] v);
      seed_load = 1'b1;
      seed_data = v;
      tick();
      seed_load = 1'b0;
   endtask

   task automatic settle();
      run = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick();
   endtask

   logic [31:0] w1;
   int c0;
   int n;
   int chg;
   int enc;

   initial begin
      w1 = 32'd1664525 * 32'h3C88596C + 32'd1013904223;
      repeat (3) tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_en", 64'(mul_enable), 64'd0);
      rst = 1'b0;
      tick();

      // seed 0, free-running sequence
      seed(32'd0);
      run = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("t1_en", 64'(mul_enable), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_mul_b", 64'(mul_b), 64'd1664525);
      c0 = cyc;
      wait_valid(50);
      chk("t1_lat", 64'(cyc - c0), 64'd8);
      chk("t1_w0", 64'(out_data), 64'h3C6EF35F);
      tick();
      wait_valid(50);
      chk("t1_w1", 64'(out_data), 64'h47502932);
      tick();
      wait_valid(50);
      chk("t1_w2", 64'(out_data), 64'hD1CCF6E9);
      tick();
      wait_valid(50);
      chk("t1_w3", 64'(out_data), 64'hAAF95334);
      settle();

      // backpressure holds exactly one word
      out_ready = 1'b0;
      seed(32'd1);
      run = 1'b1;
      wait_valid(50);
      chk("t2_w0", 64'(out_data), 64'h3C88596C);
      chg = 0;
      enc = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!out_valid || out_data != 32'h3C88596C) chg++;
         if (mul_enable) enc++;
      end
      chk("t2_hold", 64'(chg), 64'd0);
      chk("t2_no_en", 64'(enc), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_valid(50);
      chk("t2_w1", 64'(out_data), 64'(w1));
      settle();

      // seed during MUL_REQ aborts the step
      seed(32'h77);
      run = 1'b1;
      wait_en(20);
      seed_load = 1'b1;
      seed_data = 32'd5;
      tick();
      seed_load = 1'b0;
      chk("t4_en_drop", 64'(mul_enable), 64'd0);
      chk("t4_busy", 64'(busy), 64'd1);
      wait_valid(50);
      chk("t4_w", 64'(out_data), 64'h3CEDF1A0);
      settle();

      // multiplier holds done after release
      hold_extra = 3;
      seed(32'd0);
      run = 1'b1;
      wait_en(20);
      n = 0;
      while (mul_enable && n < 50) begin
         tick();
         n++;
      end
      c0 = cyc;
      chk("t5_done_held", 64'(mul_done), 64'd1);
      wait_valid(50);
      chk("t5_lat", 64'(cyc - c0), 64'd6);
      chk("t5_w", 64'(out_data), 64'h3C6EF35F);
      settle();
      hold_extra = 0;
      chk("t5_no_rereq", 64'(viol), 64'd0);

      // multiplier never completes
      hang = 1'b1;
      run = 1'b1;
      wait_en(20);
      c0 = cyc;
      n = 0;
      while (!err && n < 200) begin
         tick();
         n++;
      end
      run = 1'b0;
      chk("t3_to_lat", 64'(cyc - c0), 64'd64);
      chk("t3_en", 64'(mul_enable), 64'd0);
      chk("t3_valid", 64'(out_valid), 64'd0);
      repeat (3) tick();
      chk("t3_sticky", 64'(err), 64'd1);
      seed(32'd9);
      chk("t3_clear", 64'(err), 64'd0);
      hang = 1'b0;
      settle();

      // reset mid-request and with a word pending
      seed(32'h1234);
      run = 1'b1;
      wait_en(20);
      rst = 1'b1;
      tick();
      chk("t6_en", 64'(mul_enable), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      out_ready = 1'b0;
      seed(32'h1234);
      run = 1'b1;
      wait_valid(50);
      rst = 1'b1;
      tick();
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_data", 64'(out_data), 64'd0);
      chk("t6_err", 64'(err), 64'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      wait_valid(50);
      chk("t6_first", 64'(out_data), 64'h3C6EF35F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
